// File: rtl/pc_if.sv
// Fetch-control bundle between the control unit / branch compare and the PC sequencer.
interface pc_if #(parameter int DATA_W = 32);
  logic                     stall;
  logic                     branch;
  logic                     jump;
  logic                     jalr;
  logic signed [DATA_W-1:0] imm;
  logic        [DATA_W-1:0] rs1;
  logic                     trap_ack;
  logic        [DATA_W-1:0] pc;
  logic        [DATA_W-1:0] pc_plus4;
  logic        [DATA_W-1:0] target;
  logic                     pc_valid;
  logic                     trap;
  logic        [DATA_W-1:0] epc;
  logic        [DATA_W-1:0] retired;

  modport master (
    output stall, branch, jump, jalr, imm, rs1, trap_ack,
    input  pc, pc_plus4, target, pc_valid, trap, epc, retired
  );

  modport slave (
    input  stall, branch, jump, jalr, imm, rs1, trap_ack,
    output pc, pc_plus4, target, pc_valid, trap, epc, retired
  );
endinterface

// File: rtl/pc_sequencer.sv
// PC register and next-PC selection for the single-cycle core: boot cycle, stall hold,
// misaligned-redirect trap with EPC capture, and a retired-instruction counter.
module pc_sequencer #(
  parameter int                 DATA_W       = 32,
  parameter logic [DATA_W-1:0]  RESET_VECTOR = '0,
  parameter logic [DATA_W-1:0]  TRAP_VECTOR  = DATA_W'(32'h0000_0100)
) (
  input  logic clk,
  input  logic rst,
  pc_if.slave  bus
);

  typedef enum logic [1:0] {BOOT, RUN, TRAP} state_t;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] pc_q, epc_q, retired_q;
  logic [DATA_W-1:0] jalr_sum, rel_sum, tgt;
  logic              redirect, misaligned;
  logic              do_advance, do_trap, do_ack;

  function automatic logic is_misaligned(input logic [DATA_W-1:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

  // Target datapath: all sums wrap modulo 2^DATA_W
  assign jalr_sum   = bus.rs1 + $unsigned(bus.imm);
  assign rel_sum    = pc_q + $unsigned(bus.imm);
  assign redirect   = bus.jalr | bus.jump | bus.branch;
  assign tgt        = bus.jalr                ? {jalr_sum[DATA_W-1:1], 1'b0} :
                      (bus.jump | bus.branch) ? rel_sum                      :
                                                pc_q + DATA_W'(4);
  assign misaligned = redirect && is_misaligned(tgt);

  assign bus.pc       = pc_q;
  assign bus.pc_plus4 = pc_q + DATA_W'(4);
  assign bus.target   = tgt;
  assign bus.epc      = epc_q;
  assign bus.retired  = retired_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= BOOT;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      BOOT:    state_nxt = RUN;
      RUN:     if (!bus.stall && misaligned) state_nxt = TRAP;
      TRAP:    if (bus.trap_ack) state_nxt = RUN;
      default: state_nxt = BOOT;
    endcase
  end

  always_comb begin
    bus.pc_valid = (state == RUN);
    bus.trap     = (state == TRAP);
    do_advance   = (state == RUN) && !bus.stall && !misaligned;
    do_trap      = (state == RUN) && !bus.stall && misaligned;
    do_ack       = (state == TRAP) && bus.trap_ack;
  end

  // PC / EPC / retire counter update
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q      <= RESET_VECTOR;
      epc_q     <= '0;
      retired_q <= '0;
    end else begin
      if (do_advance) begin
        pc_q      <= tgt;
        retired_q <= retired_q + DATA_W'(1);
      end else if (do_ack) begin
        pc_q      <= TRAP_VECTOR;
      end
      if (do_trap) epc_q <= pc_q;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: boot, branch/wrap, priority, trap entry/exit, stall, async reset.
module tb_pc_sequencer;
  logic clk;
  logic rst;
  int   checks;
  int   errors;
  logic [31:0] exp_ret;
  logic [31:0] saved_ret;

  pc_if #(.DATA_W(32)) bus ();

  pc_sequencer dut (.clk(clk), .rst(rst), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.stall = 0; bus.branch = 0; bus.jump = 0; bus.jalr = 0;
    bus.imm = '0; bus.rs1 = '0; bus.trap_ack = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (bus.pc !== 32'h0)      begin errors++; $display("FAIL reset_pc got %h want %h", bus.pc, 32'h0); end
    checks++; if (bus.pc_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", bus.pc_valid); end
    checks++; if (bus.trap !== 1'b0)     begin errors++; $display("FAIL reset_trap got %b want 0", bus.trap); end
    checks++; if (bus.epc !== 32'h0)     begin errors++; $display("FAIL reset_epc got %h want 0", bus.epc); end
    checks++; if (bus.retired !== 32'h0) begin errors++; $display("FAIL reset_retired got %h want 0", bus.retired); end
    rst = 1'b0;
    step();
    checks++; if (bus.pc !== 32'h0 || bus.pc_valid !== 1'b1) begin errors++; $display("FAIL boot_c1 got pc=%h v=%b want pc=0 v=1", bus.pc, bus.pc_valid); end
    step();
    checks++; if (bus.pc !== 32'h4 || bus.pc_valid !== 1'b1) begin errors++; $display("FAIL boot_c2 got pc=%h v=%b want pc=4 v=1", bus.pc, bus.pc_valid); end
    step();
    checks++; if (bus.pc !== 32'h8 || bus.pc_valid !== 1'b1) begin errors++; $display("FAIL boot_c3 got pc=%h v=%b want pc=8 v=1", bus.pc, bus.pc_valid); end
    checks++; if (bus.retired !== 32'd2) begin errors++; $display("FAIL boot_retired got %0d want 2", bus.retired); end
    exp_ret = 32'd2;
  endtask

  task automatic test_branch_wrap();
    bus.jump = 1; bus.imm = 32'sd92;
    step(); exp_ret++;
    bus.jump = 0; bus.branch = 1; bus.imm = -32'sd4;
    #1;
    checks++; if (bus.target !== 32'd96) begin errors++; $display("FAIL branch_target got %0d want 96", bus.target); end
    step(); exp_ret++;
    checks++; if (bus.pc !== 32'd96) begin errors++; $display("FAIL branch_back got %0d want 96", bus.pc); end
    bus.branch = 0; bus.jump = 1; bus.imm = 32'hFFFF_FF9C;
    step(); exp_ret++;
    bus.jump = 0; bus.imm = '0;
    #1;
    checks++; if (bus.pc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_setup got %h want fffffffc", bus.pc); end
    checks++; if (bus.pc_plus4 !== 32'h0 || bus.target !== 32'h0) begin errors++; $display("FAIL wrap_plus4 got p4=%h tgt=%h want 0", bus.pc_plus4, bus.target); end
    step(); exp_ret++;
    checks++; if (bus.pc !== 32'h0) begin errors++; $display("FAIL wrap_pc got %h want 0", bus.pc); end
    checks++; if (bus.retired !== exp_ret) begin errors++; $display("FAIL wrap_retired got %0d want %0d", bus.retired, exp_ret); end
  endtask

  task automatic test_priority();
    bus.jump = 1; bus.imm = 32'sd100;
    step(); exp_ret++;
    bus.jalr = 1; bus.jump = 1; bus.branch = 1; bus.rs1 = 32'd200; bus.imm = 32'sd9;
    #1;
    checks++; if (bus.target !== 32'd208) begin errors++; $display("FAIL prio_target got %0d want 208", bus.target); end
    step(); exp_ret++;
    checks++; if (bus.pc !== 32'd208) begin errors++; $display("FAIL prio_pc got %0d want 208", bus.pc); end
    idle_inputs();
  endtask

  task automatic test_trap();
    bus.jump = 1; bus.imm = -32'sd108;
    step(); exp_ret++;
    checks++; if (bus.pc !== 32'd100) begin errors++; $display("FAIL trap_setup got %0d want 100", bus.pc); end
    saved_ret = bus.retired;
    bus.imm = 32'sd6;
    step();
    checks++; if (bus.trap !== 1'b1 || bus.pc_valid !== 1'b0) begin errors++; $display("FAIL trap_entry got trap=%b v=%b want trap=1 v=0", bus.trap, bus.pc_valid); end
    checks++; if (bus.epc !== 32'd100 || bus.pc !== 32'd100) begin errors++; $display("FAIL trap_epc got epc=%0d pc=%0d want 100/100", bus.epc, bus.pc); end
    checks++; if (bus.retired !== exp_ret) begin errors++; $display("FAIL trap_retired got %0d want %0d", bus.retired, exp_ret); end
    bus.imm = 32'sd8; bus.stall = 1; bus.jalr = 1; bus.rs1 = 32'd40;
    step();
    checks++; if (bus.trap !== 1'b1 || bus.pc !== 32'd100) begin errors++; $display("FAIL trap_hold got trap=%b pc=%0d want 1/100", bus.trap, bus.pc); end
    idle_inputs();
    bus.trap_ack = 1;
    step();
    checks++; if (bus.pc !== 32'd256 || bus.trap !== 1'b0 || bus.pc_valid !== 1'b1) begin errors++; $display("FAIL trap_ack got pc=%0d trap=%b v=%b want 256/0/1", bus.pc, bus.trap, bus.pc_valid); end
    checks++; if (bus.retired !== exp_ret) begin errors++; $display("FAIL ack_retired got %0d want %0d", bus.retired, exp_ret); end
    bus.trap_ack = 0;
    step(); exp_ret++;
    checks++; if (bus.pc !== 32'd260 || bus.retired !== exp_ret) begin errors++; $display("FAIL post_trap got pc=%0d ret=%0d want 260/%0d", bus.pc, bus.retired, exp_ret); end
  endtask

  task automatic test_stall();
    bus.stall = 1; bus.branch = 1; bus.imm = 32'sd8;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (bus.pc !== 32'd260 || bus.retired !== exp_ret) begin errors++; $display("FAIL stall_hold%0d got pc=%0d ret=%0d want 260/%0d", i, bus.pc, bus.retired, exp_ret); end
    end
    bus.stall = 0;
    step(); exp_ret++;
    checks++; if (bus.pc !== 32'd268 || bus.retired !== exp_ret) begin errors++; $display("FAIL stall_release got pc=%0d ret=%0d want 268/%0d", bus.pc, bus.retired, exp_ret); end
    bus.branch = 0; bus.stall = 1; bus.jump = 1; bus.imm = 32'sd2;
    step();
    checks++; if (bus.trap !== 1'b0 || bus.pc !== 32'd268) begin errors++; $display("FAIL stall_no_trap got trap=%b pc=%0d want 0/268", bus.trap, bus.pc); end
    idle_inputs();
    bus.trap_ack = 1;
    step(); exp_ret++;
    checks++; if (bus.pc !== 32'd272 || bus.retired !== exp_ret) begin errors++; $display("FAIL ack_outside_trap got pc=%0d ret=%0d want 272/%0d", bus.pc, bus.retired, exp_ret); end
    bus.trap_ack = 0;
  endtask

  task automatic test_reset_mid_trap();
    bus.jump = 1; bus.imm = 32'sd2;
    step();
    checks++; if (bus.trap !== 1'b1 || bus.epc !== 32'd272) begin errors++; $display("FAIL mid_trap_entry got trap=%b epc=%0d want 1/272", bus.trap, bus.epc); end
    idle_inputs();
    #2;
    rst = 1'b1;
    #1;
    checks++; if (bus.pc !== 32'h0 || bus.trap !== 1'b0 || bus.pc_valid !== 1'b0) begin errors++; $display("FAIL async_rst got pc=%h trap=%b v=%b want 0/0/0", bus.pc, bus.trap, bus.pc_valid); end
    checks++; if (bus.epc !== 32'h0 || bus.retired !== 32'h0) begin errors++; $display("FAIL async_rst_regs got epc=%h ret=%h want 0/0", bus.epc, bus.retired); end
    step();
    rst = 1'b0;
    checks++; if (bus.pc_valid !== 1'b0) begin errors++; $display("FAIL rst_boot got v=%b want 0", bus.pc_valid); end
    step();
    checks++; if (bus.pc !== 32'h0 || bus.pc_valid !== 1'b1) begin errors++; $display("FAIL rst_run got pc=%h v=%b want 0/1", bus.pc, bus.pc_valid); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    exp_ret = '0;
    saved_ret = '0;
    test_reset();
    test_branch_wrap();
    test_priority();
    test_trap();
    test_stall();
    test_reset_mid_trap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Program-counter sequencer for the single-cycle RISC-V core. It owns the PC register and chooses the next PC each cycle from PC+4, the branch/JAL target (PC + imm) or the JALR target ((rs1 + imm) with bit 0 cleared). It computes the same sums as the PC_Branch adder path, in place of the loose adder/mux chain, and adds a boot cycle, stall hold, misaligned-target trapping and a retired-instruction counter. It sits between the control unit/ALU compare outputs and the instruction memory address port.

## Interface
- RESET_VECTOR, 32'h0000_0000: PC loaded on reset.
- TRAP_VECTOR, 32'h0000_0100: PC loaded when a trap is acknowledged.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- stall_i  input  1  hold PC; in RUN, no advance.
- branch_i  input  1  conditional branch taken (branch & condition, resolved outside).
- jump_i  input  1  JAL.
- jalr_i  input  1  JALR.
- imm_i  input  32  sign-extended immediate.
- rs1_i  input  32  rs1 value for JALR.
- trap_ack_i  input  1  trap handler acknowledge.
- pc_o  output  32  current PC (registered).
- pc_plus4_o  output  32  pc_o + 4 (combinational, link value).
- target_o  output  32  selected redirect target (combinational).
- pc_valid_o  output  1  pc_o holds a fetchable instruction (registered).
- trap_o  output  1  misaligned-target trap pending (registered).
- epc_o  output  32  PC of the instruction that caused the trap (registered).
- retired_o  output  32  count of PC advances (registered).

## Operation
- States: BOOT, RUN, TRAP. Reset → BOOT.
- Reset values: pc_o=RESET_VECTOR, pc_valid_o=0, trap_o=0, epc_o=0, retired_o=0.
- BOOT: lasts one cycle, always → RUN. pc_o stays unchanged; inputs (including stall_i) are ignored.
- RUN: pc_valid_o=1. Redirect priority is jalr_i > jump_i > branch_i > sequential.
  - jalr target = (rs1_i + imm_i) & ~32'h1.
  - jump/branch target = pc_o + imm_i.
  - All adds are 32-bit, modulo 2^32. Carries are dropped, so 32'hFFFF_FFFC + 4 = 0.
  - target_o shows the selected redirect target. With no redirect, target_o = pc_plus4_o.
- Alignment: if a redirect is selected and target_o[1:0] != 0 (checked after the JALR bit-0 clear):
  - next state is TRAP; epc_o <= pc_o; pc_o is unchanged; retired_o is not incremented.
- Normal advance (no misalignment): pc_o <= target_o and retired_o <= retired_o + 1, wrapping at 2^32.
- stall_i=1 in RUN: pc_o, retired_o and state all hold. A misaligned target is not trapped while stalled.
- TRAP: pc_valid_o=0, trap_o=1, pc_o held, and all redirect/stall inputs are ignored.
  - trap_ack_i=1 → pc_o <= TRAP_VECTOR, state goes to RUN, trap_o clears.
  - retired_o is not incremented on this transition.
- trap_ack_i outside TRAP has no effect.
- rst asserted in any state, mid-stall or mid-trap included, immediately forces the reset values and BOOT.

## Timing
- All registered outputs change only on the rising edge of clk, or asynchronously on rst.
- pc_plus4_o and target_o are combinational from pc_o and the current inputs, valid in the same cycle.
- Redirect latency is 1 cycle: inputs sampled at edge N are reflected in pc_o after edge N.
- First valid fetch: pc_valid_o=1 in the cycle after the BOOT edge, i.e. 1 cycle after rst deasserts.
- Trap entry: trap_o rises at the edge where the misaligned redirect is sampled.
  - Minimum TRAP residency is 1 cycle. trap_ack_i is sampled starting at the first edge in TRAP.
- Stall and redirect in the same cycle: stall wins and the redirect is dropped. Control holds its inputs while stalling.

## Test plan
- Reset/boot: hold rst, release, run 3 cycles with no redirects.
  - Required: pc_o = 0, 0, 4, 8; pc_valid_o = 0, 1, 1, 1; retired_o reaches 2.
- Branch and wrap:
  - pc_o=100, branch_i=1, imm_i=-4 → pc_o=96.
  - pc_o=32'hFFFF_FFFC, sequential → pc_o=0.
- Priority: pc_o=100, jalr_i=jump_i=branch_i=1, rs1_i=200, imm_i=9.
  - Required: target_o=208 (209 with bit 0 cleared); next pc_o=208 (JALR wins).
- Misaligned trap: pc_o=100, jump_i=1, imm_i=6.
  - Required: trap_o=1, epc_o=100, pc_o stays 100, pc_valid_o=0, retired_o unchanged.
  - Then trap_ack_i=1 → pc_o=256, trap_o=0, state RUN.
- Stall: stall_i=1 for 3 cycles while branch_i=1, imm_i=8.
  - Required: pc_o and retired_o hold. After stall_i drops, pc_o advances to pc+8.
- Reset mid-trap: enter TRAP, then assert rst asynchronously between edges.
  - Required: all outputs return to their reset values immediately, without waiting for a clock edge.
